// File: rtl/step_tick_gen.sv
// step_tick_gen: paces the display counter. Produces a registered one-cycle
// count-enable pulse (tick) either at a selectable rate or from a debounced
// manual single-step push-button.
module step_tick_gen #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 28,
  parameter int DB_W         = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] frequency,
  input  logic       step_key,
  output logic       tick,
  output logic       key_level
);

  localparam logic [1:0] FREQ_FULL    = 2'b00;
  localparam logic [1:0] FREQ_1HZ     = 2'b01;
  localparam logic [1:0] FREQ_HALF_HZ = 2'b10;

  // Reload values are period-1 so the divider spends exactly P cycles per hit.
  localparam logic [CNT_W-1:0] RELOAD_1HZ     = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] RELOAD_HALF_HZ = CNT_W'(2 * CLK_HZ - 1);
  localparam logic [CNT_W-1:0] RELOAD_QTR_HZ  = CNT_W'(4 * CLK_HZ - 1);
  localparam logic [DB_W-1:0]  DB_LAST        = DB_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       freq_q, freq_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             key_level_q, key_level_d;
  logic             key_prev_q, key_prev_d;
  logic             tick_q, tick_d;
  logic             rate_hit;
  logic             step_hit;
  logic             key_s;

  // Divider reload value for a given rate select; full speed never counts.
  function automatic logic [CNT_W-1:0] reload_for(input logic [1:0] f);
    logic [CNT_W-1:0] r;
    case (f)
      FREQ_FULL:    r = '0;
      FREQ_1HZ:     r = RELOAD_1HZ;
      FREQ_HALF_HZ: r = RELOAD_HALF_HZ;
      default:      r = RELOAD_QTR_HZ;
    endcase
    return r;
  endfunction

  // Rate divider: restarts on any rate change, otherwise counts enabled cycles.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    freq_d    = frequency;
    div_cnt_d = div_cnt_q;
    rate_hit  = 1'b0;
    if (frequency != freq_q) begin
      div_cnt_d = reload_for(frequency);
    end else if (frequency == FREQ_FULL) begin
      rate_hit = enable;
    end else if (enable) begin
      if (div_cnt_q == '0) begin
        rate_hit  = 1'b1;
        div_cnt_d = reload_for(frequency);
      end else begin
        div_cnt_d = div_cnt_q - 1'b1;
      end
    end
  end

  // Key path: two-flop synchroniser, then a stability counter that only
  // accepts a new level after it has persisted for DEBOUNCE_CYC cycles.
  always_comb begin
    sync1_d     = step_key;
    sync2_d     = sync1_q;
    key_s       = sync2_q;
    db_cnt_d    = db_cnt_q;
    key_level_d = key_level_q;
    if (key_s == key_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      key_level_d = key_s;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Press detect on the debounced level, then merge with the rate hit.
  always_comb begin
    key_prev_d = key_level_q;
    step_hit   = key_prev_q & ~key_level_q;
    tick_d     = rate_hit | step_hit;
  end

  // State registers; everything returns to idle immediately on reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!reset_n) begin
      freq_q      <= FREQ_FULL;
      div_cnt_q   <= '0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_cnt_q    <= '0;
      key_level_q <= 1'b1;
      key_prev_q  <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      freq_q      <= freq_d;
      div_cnt_q   <= div_cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      key_level_q <= key_level_d;
      key_prev_q  <= key_prev_d;
      tick_q      <= tick_d;
    end
  end

  assign tick      = tick_q;
  assign key_level = key_level_q;

endmodule

// File: tb/tb_step_tick_gen.sv
// Bench for step_tick_gen with a small clock rate and short debounce so every
// rate mode, the key path and reset behaviour fit in a few hundred cycles.
module tb_step_tick_gen;

  localparam int CLK_HZ = 8;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] frequency = 2'b00;
  logic       step_key = 1'b1;
  logic       tick;
  logic       key_level;

  int cyc = 0;       // number of rising edges seen so far
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];      // rising-edge numbers at which tick must become high

  step_tick_gen #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB), .CNT_W(6), .DB_W(3)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .frequency(frequency),
    .step_key (step_key),
    .tick     (tick),
    .key_level(key_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Wait until the falling edge that follows rising edge number n.
  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard monitor: on every falling edge compare tick against the queue.
  task automatic monitor();
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("tick_missed_edge", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        check($sformatf("tick_at_%0d", cyc), int'(tick), 1);
        void'(exp_q.pop_front());
      end else if (tick !== 1'b0) begin
        check($sformatf("unexpected_tick_at_%0d", cyc), int'(tick), 0);
      end
    end
  endtask

  initial begin
    int t;
    int r;
    logic pat[4];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1};

    fork
      monitor();
    join_none

    // Reset state
    reset_n = 1'b0; frequency = 2'b01; enable = 1'b1; step_key = 1'b1;
    wait_to(2);
    check("reset_tick", int'(tick), 0);
    check("reset_key_level", int'(key_level), 1);

    // 1: 1 Hz mode, reload on first cycle, tick every 8 cycles
    t = cyc;
    reset_n = 1'b1;
    exp_q.push_back(t + 9);
    exp_q.push_back(t + 17);
    exp_q.push_back(t + 25);
    wait_to(t + 28);

    // 2: full speed, enable pattern 1,1,0,1 mirrored one cycle later
    t = cyc;
    frequency = 2'b00; enable = 1'b0;
    exp_q.push_back(t + 2);
    exp_q.push_back(t + 3);
    exp_q.push_back(t + 5);
    for (int i = 0; i < 4; i++) begin
      wait_to(t + 1 + i);
      enable = pat[i];
    end
    wait_to(t + 5);
    enable = 1'b0;
    wait_to(t + 8);

    // 3: 0.25 Hz with a 10-cycle enable gap stretching one period to 42
    t = cyc;
    frequency = 2'b11; enable = 1'b1;
    exp_q.push_back(t + 33);
    exp_q.push_back(t + 75);
    wait_to(t + 40); enable = 1'b0;
    wait_to(t + 50); enable = 1'b1;
    wait_to(t + 76); enable = 1'b0;
    wait_to(t + 80);

    // 4: short glitch ignored, long press ticks once, release silent
    t = cyc;
    step_key = 1'b0;
    wait_to(t + 3); step_key = 1'b1;
    wait_to(t + 12);
    check("glitch_key_level", int'(key_level), 1);
    t = cyc;
    step_key = 1'b0;
    exp_q.push_back(t + 7);
    wait_to(t + 10);
    check("pressed_key_level", int'(key_level), 0);
    wait_to(t + 20); step_key = 1'b1;
    wait_to(t + 35);
    check("released_key_level", int'(key_level), 1);

    // 5: rate switch 10 -> 01 mid-count, step press merged with a rate hit
    t = cyc;
    frequency = 2'b10; enable = 1'b1;
    exp_q.push_back(t + 17);
    wait_to(t + 22);
    frequency = 2'b01;
    exp_q.push_back(t + 31);
    exp_q.push_back(t + 39);
    exp_q.push_back(t + 47);
    wait_to(t + 32); step_key = 1'b0;
    wait_to(t + 42); step_key = 1'b1;
    wait_to(t + 48); enable = 1'b0;
    wait_to(t + 55);

    // 6: asynchronous reset while tick is high and the key is held
    t = cyc;
    step_key = 1'b0;
    exp_q.push_back(t + 7);
    wait_to(t + 7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_tick", int'(tick), 0);
    check("async_reset_key_level", int'(key_level), 1);
    step_key = 1'b1; frequency = 2'b01; enable = 1'b1;
    wait_to(t + 10);
    r = cyc;
    reset_n = 1'b1;
    exp_q.push_back(r + 9);
    exp_q.push_back(r + 17);
    wait_to(r + 20); enable = 1'b0;
    wait_to(r + 30);

    check("pending_expected_ticks", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
